// File: rtl/r32_ctrl_seq_if.sv
// r32_ctrl_seq_if: start strobe plus status and select bundle between the frame loader and the sequencer.
// master: drives start and observes every status and select line (frame loader side).
// slave : receives start and drives busy, done, sel1, sel5, sel6, sel4, sel, sel2, sel7, clr and En.
interface r32_ctrl_seq_if;
   logic start, busy, done, sel1, sel5, sel6, sel4, sel, sel2, sel7, clr, En;
   modport master (output start, input busy, done, sel1, sel5, sel6, sel4, sel, sel2, sel7, clr, En);
   modport slave (input start, output busy, done, sel1, sel5, sel6, sel4, sel, sel2, sel7, clr, En);
endinterface

// File: rtl/r32_ctrl_seq.sv
// r32_ctrl_seq: control sequencer producing the Radix-3^2 butterfly selects, clear pulse and enable.
// Ports: clk, rst (async, active-high), bus (slave side): start in; busy, done, sel1, sel5, sel6,
// sel4, sel, sel2, sel7, clr, En out. All outputs come straight from flops.
module r32_ctrl_seq #(
   parameter int unsigned LEN     = 64,
   parameter int unsigned OFF_S4  = 4,
   parameter int unsigned OFF_S   = 5,
   parameter int unsigned OFF_S2  = 7,
   parameter int unsigned OFF_S7  = 8,
   parameter int unsigned OFF_CLR = 11
) (
   input  logic               clk,
   input  logic               rst,
   r32_ctrl_seq_if.slave      bus
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam logic [15:0] LAST = 16'(LEN - 1);
   // Slot order: sel1, sel5, sel6, sel4, sel, sel2, sel7, clr (index 0..7).
   localparam logic [7:0][15:0] OFFS = {16'(OFF_CLR), 16'(OFF_S7), 16'(OFF_S2), 16'(OFF_S),
                                        16'(OFF_S4), 16'd0, 16'd0, 16'd0};
   localparam logic [7:0][2:0] MODS = {3'd3, 3'd6, 3'd3, 3'd3, 3'd6, 3'd3, 3'd3, 3'd2};
   state_t state, state_n;
   logic [15:0] cnt, cnt_n, nk;
   logic [7:0][2:0] ph, ph_n;
   logic [7:0] act;
   logic [10:0] outs_n;
   logic run_n;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   always_comb
      state_n = state == IDLE ? (bus.start ? RUN : IDLE) : (cnt == LAST ? IDLE : RUN);
   // nk is the cycle index the next edge registers; phases and outputs are computed for it so
   // the registered values line up with the cycle they belong to.
   always_comb begin
      run_n = state_n == RUN;
      nk = state == IDLE ? 16'd0 : cnt + 16'd1;
      cnt_n = run_n ? nk : 16'd0;
      for (int i = 0; i < 8; i++) begin
         act[i] = run_n && nk >= OFFS[i];
         ph_n[i] = (!act[i] || nk == OFFS[i] || ph[i] == MODS[i] - 3'd1) ? 3'd0 : ph[i] + 3'd1;
      end
      outs_n = {run_n, state == RUN && state_n == IDLE,
                act[0] && ph_n[0] == 3'd1,
                act[1] && ph_n[1] != 3'd1,
                act[2] && ph_n[2] == 3'd0,
                act[3] && ph_n[3] >= 3'd3,
                act[4] && ph_n[4] != 3'd0,
                act[5] && ph_n[5] != 3'd0,
                act[6] && ph_n[6] >= 3'd3,
                act[7] && ph_n[7] == 3'd0,
                act[7]};
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         ph <= '0;
         {bus.busy, bus.done, bus.sel1, bus.sel5, bus.sel6, bus.sel4, bus.sel, bus.sel2, bus.sel7, bus.clr, bus.En} <= '0;
      end else begin
         cnt <= cnt_n;
         ph <= ph_n;
         {bus.busy, bus.done, bus.sel1, bus.sel5, bus.sel6, bus.sel4, bus.sel, bus.sel2, bus.sel7, bus.clr, bus.En} <= outs_n;
      end
endmodule

// File: tb/tb_r32_ctrl_seq.sv
// tb_r32_ctrl_seq: random and directed start/reset stimulus on LEN=64 and LEN=12 sequencers against a cycle-index model.
module tb_r32_ctrl_seq;
   logic clk = 0, rst = 1, start = 0;
   int n_checks = 0, n_errors = 0;
   int ka = -1, kb = -1;
   logic [10:0] obs_a, obs_b;
   r32_ctrl_seq_if bus_a ();
   r32_ctrl_seq_if bus_b ();
   assign bus_a.start = start;
   assign bus_b.start = start;
   r32_ctrl_seq dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   r32_ctrl_seq #(.LEN(12)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
   assign obs_a = {bus_a.busy, bus_a.done, bus_a.sel1, bus_a.sel5, bus_a.sel6, bus_a.sel4,
                   bus_a.sel, bus_a.sel2, bus_a.sel7, bus_a.clr, bus_a.En};
   assign obs_b = {bus_b.busy, bus_b.done, bus_b.sel1, bus_b.sel5, bus_b.sel6, bus_b.sel4,
                   bus_b.sel, bus_b.sel2, bus_b.sel7, bus_b.clr, bus_b.En};
   always #5 clk = ~clk;

   // k = cycle index within the frame, len = done cycle, -1 = idle.
   function automatic logic [10:0] expv(int k, int len);
      logic r;
      r = k >= 0 && k < len;
      return {r, k == len, r && k % 2 == 1, r && k % 3 != 1, r && k % 3 == 0,
              r && k >= 4 && (k - 4) % 6 >= 3, r && k >= 5 && (k - 5) % 3 != 0,
              r && k >= 7 && (k - 7) % 3 != 0, r && k >= 8 && (k - 8) % 6 >= 3,
              r && k >= 11 && (k - 11) % 3 == 0, r && k >= 11};
   endfunction

   function automatic int adv(int k, int len, logic s, logic r);
      if (r) return -1;
      if (k >= 0 && k < len) return k + 1;
      return s ? 0 : -1;
   endfunction

   task automatic check(string tag, logic [10:0] got, logic [10:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s t=%0t got=%b exp=%b (busy,done,sel1,sel5,sel6,sel4,sel,sel2,sel7,clr,En)", tag, $time, got, exp);
      end
   endtask

   task automatic step();
      logic s, r;
      s = start;
      r = rst;
      @(posedge clk);
      ka = adv(ka, 64, s, r);
      kb = adv(kb, 12, s, r);
      #1;
      check($sformatf("len64 k=%0d", ka), obs_a, expv(ka, 64));
      check($sformatf("len12 k=%0d", kb), obs_b, expv(kb, 12));
   endtask

   task automatic steps(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic async_reset();
      rst = 1;
      #1;
      ka = -1;
      kb = -1;
      check("rst_immediate_a", obs_a, '0);
      check("rst_immediate_b", obs_b, '0);
      step();
      rst = 0;
   endtask

   initial begin
      #2;
      check("reset_a", obs_a, '0);
      check("reset_b", obs_b, '0);
      steps(3);
      rst = 0;
      steps(20);
      start = 1; step(); start = 0;
      steps(70);
      start = 1; step(); start = 0;
      steps(19);
      start = 1; step(); start = 0;
      steps(60);
      start = 1; steps(140); start = 0;
      steps(70);
      start = 1; step(); start = 0;
      steps(30);
      #2;
      async_reset();
      steps(10);
      start = 1; step(); start = 0;
      steps(70);
      for (int i = 0; i < 2500; i++) begin
         start = $urandom_range(0, 7) == 0;
         if ($urandom_range(0, 299) == 0) begin
            #2;
            async_reset();
         end else step();
      end
      start = 0;
      steps(70);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/r32_ctrl_seq.md
Name: r32_ctrl_seq

Overview:
- Control sequencer for the Radix-3^2 butterfly datapath (Radix_32).
- Generates the mux selects sel, sel1, sel2, sel4, sel5, sel6 and sel7, the periodic accumulator-clear pulse (wired to the datapath's rst pin) and the En enable, each with the correct per-stage start offset.
- Replaces hand-driven bench waveforms, so a frame runs from a single start strobe.
- Sits beside Radix_32 in the FFT top level and is driven by the frame loader.

Parameters:
- LEN, 64, cycles per frame run (must be 2..65535)
- OFF_S4, 4, cycle at which the sel4 pattern starts
- OFF_S, 5, cycle at which the sel pattern starts
- OFF_S2, 7, cycle at which the sel2 pattern starts
- OFF_S7, 8, cycle at which the sel7 pattern starts
- OFF_CLR, 11, cycle at which clr and En start (must be < LEN)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  frame start strobe
- busy  out  1  high while a frame runs
- done  out  1  one-cycle pulse after a frame completes
- sel1  out  1  period-2 select
- sel5  out  1  period-3 select
- sel6  out  1  period-3 select
- sel4  out  1  period-6 select
- sel  out  1  period-3 select
- sel2  out  1  period-3 select
- sel7  out  1  period-6 select
- clr  out  1  accumulator-clear pulse to the datapath
- En  out  1  datapath enable

Behaviour:
- Single clock, clk. Reset rst is asynchronous and active-high.
- Reset: state IDLE, cycle counter 0, all phase counters 0, every output 0.
- States:
  - IDLE -> RUN when start=1 at a clock edge.
  - RUN -> IDLE at the edge ending cycle LEN-1.
  - No other states.
- Cycle numbering: the edge that samples start in IDLE is E0. Cycle k means the values registered at edge Ek. All outputs are registered; there are no combinational paths from start.
- busy=1 for cycles 0..LEN-1 and 0 otherwise.
- done=1 in cycle LEN only, then 0.
- Patterns in RUN. p = k - OFF_x for the given output; the output is 0 while k < OFF_x.
  - sel1: k even -> 0, k odd -> 1 (starts at cycle 0).
  - sel5: k mod 3 = 0,1,2 -> 1,0,1.
  - sel6: k mod 3 = 0,1,2 -> 1,0,0.
  - sel4: p mod 6 in 0..2 -> 0, in 3..5 -> 1.
  - sel: p mod 3 = 0 -> 0, else 1.
  - sel2: same as sel, using OFF_S2.
  - sel7: same as sel4, using OFF_S7.
  - clr: p mod 3 = 0 -> 1, else 0.
  - En: 1 for all k >= OFF_CLR.
- Implementation: each output has its own mod-2, mod-3 or mod-6 phase counter, held at 0 until its offset is reached. No dividers.
- start while busy=1 is ignored and does not restart the frame.
- start during the done cycle is accepted: the next edge is E0 of a new frame and done still pulses for that one cycle.
- End of frame: in cycle LEN every select, clr and En return to 0, and all phase counters clear.
- Reset asserted mid-frame: immediate return to the reset values, including busy=0 and done=0; no done pulse is generated.
- Cycle counter is 16 bits and never wraps, because LEN is capped at 65535.

Test Plan:
- Reset held then released, no start -> every output stays 0 for 20 cycles.
- Single start pulse with LEN=64:
  - sel1 reads 0,1,0,1,... from cycle 0.
  - sel5 reads 1,0,1,1,0,1 and sel6 reads 1,0,0,1,0,0 over cycles 0..5.
  - sel4 is 0 at cycles 0..6, 1 at cycles 7..9 and 0 at cycles 10..12.
  - sel is 0,0,0,0,0,0,1,1,0 over cycles 0..8.
  - sel2 is 0 through cycle 7 and 1 at cycles 8..9.
  - sel7 is 0 at cycles 0..10 and 1 at cycles 11..13.
  - clr is 1 at cycles 11,14,17,...; En is 1 from cycle 11.
  - busy is 1 at cycles 0..63; done is 1 at cycle 64 only.
- start asserted again at cycle 20 of a running frame -> waveforms are identical to the single-pulse run and done still lands at cycle 64.
- start held high continuously -> done at cycle 64 and a new frame's cycle 0 at cycle 65; the new frame is a bit-exact repeat.
- rst asserted at cycle 30 -> outputs are 0 in the same cycle, no done pulse follows, and a later start produces a clean frame.
- LEN=12 override -> the single clr pulse is at cycle 11, En is 1 only at cycle 11, and done is at cycle 12.
